// File: rtl/seq_pattern_gen_if.sv
//==============================================================================
// Module      : seq_pattern_gen_if
// Description : Load handshake and serial stream bundle for seq_pattern_gen.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface seq_pattern_gen_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1)
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LEN_W-1:0] load_len;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data, load_len,
    input  load_ready, dout, dout_valid, busy, done
  );

  modport slave (
    input  load_valid, load_data, load_len,
    output load_ready, dout, dout_valid, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/seq_pattern_gen.sv
//==============================================================================
// Module      : seq_pattern_gen
// Description : MSB-first bit-serial pattern transmitter with gapless chaining.
//               Optional word repeat enabled by SEQ_PATTERN_GEN_REPEAT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
`ifdef SEQ_PATTERN_GEN_REPEAT_EN
  input  wire logic          repeat_req,
`endif
  seq_pattern_gen_if.slave   bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] C_LEN_MAX = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] C_ONE     = LEN_W'(1);
  localparam logic [LEN_W-1:0] C_TWO     = LEN_W'(2);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sreg, w_sreg_nxt;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_dout, w_dout_nxt;
  logic             r_dv, w_dv_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  logic [LEN_W-1:0] w_len_eff;
  logic [WIDTH-1:0] w_aligned;
  logic             w_fire;
  logic             w_ld;
  logic [WIDTH-1:0] w_ld_word;
  logic [LEN_W-1:0] w_ld_len;

  // Counter holds the bits still to be shown, including the one on dout now.
  assign bus.load_ready = (r_state == S_IDLE) || (r_state == S_SHIFT && r_cnt == C_ONE);
  assign w_fire         = bus.load_valid && bus.load_ready;

  assign w_len_eff = (bus.load_len == '0 || bus.load_len > C_LEN_MAX) ? C_LEN_MAX : bus.load_len;
  // Left shift drops the don't-care bits above len-1 off the top.
  assign w_aligned = bus.load_data << (C_LEN_MAX - w_len_eff);

`ifdef SEQ_PATTERN_GEN_REPEAT_EN
  logic [WIDTH-1:0] r_save_word;
  logic [LEN_W-1:0] r_save_len;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_save_word <= '0;
      r_save_len  <= '0;
    end else if (w_fire) begin
      r_save_word <= w_aligned;
      r_save_len  <= w_len_eff;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    w_cnt_nxt   = r_cnt;
    w_dout_nxt  = 1'b0;
    w_dv_nxt    = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_ld        = 1'b0;
    w_ld_word   = w_aligned;
    w_ld_len    = w_len_eff;

    if (w_fire) begin
      w_ld = 1'b1;
    end
`ifdef SEQ_PATTERN_GEN_REPEAT_EN
    else if (r_state == S_SHIFT && r_cnt == C_ONE && repeat_req) begin
      w_ld      = 1'b1;
      w_ld_word = r_save_word;
      w_ld_len  = r_save_len;
    end
`endif

    if (w_ld) begin
      w_state_nxt = S_SHIFT;
      w_dout_nxt  = w_ld_word[WIDTH-1];
      w_sreg_nxt  = w_ld_word << 1;
      w_cnt_nxt   = w_ld_len;
      w_dv_nxt    = 1'b1;
      w_busy_nxt  = 1'b1;
      w_done_nxt  = (w_ld_len == C_ONE);
    end else if (r_state == S_SHIFT && r_cnt > C_ONE) begin
      w_dout_nxt  = r_sreg[WIDTH-1];
      w_sreg_nxt  = r_sreg << 1;
      w_cnt_nxt   = r_cnt - C_ONE;
      w_dv_nxt    = 1'b1;
      w_busy_nxt  = 1'b1;
      w_done_nxt  = (r_cnt == C_TWO);
    end else begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_dout  <= 1'b0;
      r_dv    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sreg  <= w_sreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= w_dout_nxt;
      r_dv    <= w_dv_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dv;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
//==============================================================================
// Module      : tb_seq_pattern_gen
// Description : Self-checking bench for seq_pattern_gen against a bit-queue model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seq_pattern_gen;

  localparam int W  = 8;
  localparam int LW = $clog2(W + 1);

  logic clk;
  logic reset_n;
`ifdef SEQ_PATTERN_GEN_REPEAT_EN
  logic repeat_req;
`endif

  seq_pattern_gen_if #(.WIDTH(W), .LEN_W(LW)) bus ();

  seq_pattern_gen #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
`ifdef SEQ_PATTERN_GEN_REPEAT_EN
    .repeat_req (repeat_req),
`endif
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Each entry is {bit, last_of_word}; q[0] is what dout should show now.
  logic [1:0]    q[$];
  logic [W-1:0]  sv_data;
  logic [LW-1:0] sv_len;
  bit            last_fire;
  int            det;
  logic [3:0]    hist;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(logic [W-1:0] d, logic [LW-1:0] l);
    int el;
    el = (l == 0 || int'(l) > W) ? W : int'(l);
    for (int i = el - 1; i >= 0; i--) q.push_back({d[i], 1'b0});
    q[q.size()-1][0] = 1'b1;
    sv_data = d;
    sv_len  = l;
  endtask

  // One clock: check ready, update the model at the edge, check outputs after.
  task automatic step();
    bit rdy_m;
    bit was_last;
    logic [3:0] exp_o;
    rdy_m = (q.size() <= 1);
    check("load_ready", 32'(bus.load_ready), 32'(rdy_m));
    @(posedge clk);
    last_fire = bus.load_valid && rdy_m;
    was_last  = (q.size() == 1);
    if (q.size() > 0) void'(q.pop_front());
    if (last_fire) push_word(bus.load_data, bus.load_len);
`ifdef SEQ_PATTERN_GEN_REPEAT_EN
    else if (was_last && repeat_req) push_word(sv_data, sv_len);
`endif
    #1;
    exp_o = (q.size() > 0) ? {q[0][1], 1'b1, 1'b1, q[0][0]} : 4'b0000;
    check("outs{dout,dv,busy,done}",
          32'({bus.dout, bus.dout_valid, bus.busy, bus.done}), 32'(exp_o));
    if (bus.dout_valid) begin
      hist = {hist[2:0], bus.dout};
      if (hist == 4'b1011) det++;
    end else begin
      hist = 4'b0000;
    end
  endtask

  task automatic send(logic [W-1:0] d, logic [LW-1:0] l);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_len   = l;
    last_fire      = 1'b0;
    for (int k = 0; k < 40 && !last_fire; k++) step();
    check("accept", 32'(last_fire), 32'd1);
    bus.load_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && q.size() > 0; k++) step();
    check("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int det0;
    int k;
    reset_n        = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_len   = '0;
`ifdef SEQ_PATTERN_GEN_REPEAT_EN
    repeat_req     = 1'b0;
`endif
    det  = 0;
    hist = 4'b0000;
    sv_data = '0;
    sv_len  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 32'({bus.dout, bus.dout_valid, bus.busy, bus.done}), 32'd0);
    reset_n = 1'b1;
    #1;
    check("reset_ready", 32'(bus.load_ready), 32'd1);
    step();

    // Single 1011 word
    det0 = det;
    send(8'h0B, 4'd4);
    drain();
    step();
    check("det_single", 32'(det - det0), 32'd1);

    // Gapless 1011 + 011 -> overlapping detections
    det0 = det;
    send(8'h0B, 4'd4);
    send(8'h03, 4'd3);
    drain();
    check("det_overlap", 32'(det - det0), 32'd2);

    // len 0 means full width; len 1 single bit
    send(8'hA5, 4'd0);
    drain();
    send(8'h01, 4'd1);
    drain();
    step();

    // Asynchronous abort in bit 2
    send(8'h0B, 4'd4);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_abort", 32'({bus.dout, bus.dout_valid, bus.busy, bus.done}), 32'd0);
    q.delete();
    hist = 4'b0000;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("ready_after_rst", 32'(bus.load_ready), 32'd1);
    send(8'h0D, 4'd4);
    drain();

    // Offer a new word mid-word: held until the last-bit cycle
    send(8'h0B, 4'd4);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h50;
    bus.load_len   = 4'd8;
    last_fire = 1'b0;
    k = 0;
    while (k < 20 && !last_fire) begin
      step();
      k++;
    end
    check("mid_accept_cycles", 32'(k), 32'd4);
    bus.load_valid = 1'b0;
    drain();

    // Randomised traffic incl. out-of-range lengths
    for (int i = 0; i < 400; i++) begin
      bus.load_valid = 1'($urandom % 2);
      bus.load_data  = 8'($urandom);
      bus.load_len   = 4'($urandom_range(0, 15));
      step();
    end
    bus.load_valid = 1'b0;
    drain();

`ifdef SEQ_PATTERN_GEN_REPEAT_EN
    repeat_req = 1'b1;
    send(8'h0B, 4'd4);
    for (int i = 0; i < 9; i++) step();
    repeat_req = 1'b0;
    drain();
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Bit-serial pattern transmitter that drives stimulus streams into serial sequence detectors (e.g. the 1011 detector) on the same clk domain.
- Accepts a parallel word plus a bit length over a valid/ready handshake.
- Shifts the word out MSB-first, one bit per clk, with a qualifying strobe.
- Supports gapless back-to-back words, so overlapping patterns such as 1011011 can be produced.

Parameters:
WIDTH, 8, maximum pattern length in bits (2..32)
LEN_W, $clog2(WIDTH+1), width of the length field

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
load_valid  input  1  a new pattern word is offered
load_ready  output  1  block can accept a word this cycle
load_data  input  WIDTH  pattern; bit [load_len-1] is sent first
load_len  input  LEN_W  number of bits to send; 0 or >WIDTH is treated as WIDTH
dout  output  1  serial data, feeds detector din
dout_valid  output  1  dout carries a pattern bit this cycle
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse coincident with the last bit of a word

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - dout=0, dout_valid=0, busy=0, done=0, load_ready=1 once reset_n deasserts.
  - All outputs are registered except load_ready.
- States:
  - IDLE: dout=0, dout_valid=0.
  - SHIFT: emitting bits.
- Accept condition: handshake fires on a clk edge where load_valid && load_ready.
- load_ready (combinational) = (state==IDLE) || (state==SHIFT && counter==1).
  - The second term is the last-bit cycle, which allows gapless chaining.
- IDLE -> SHIFT on accept:
  - Left-align load_data so bit [len-1] sits at the register MSB; counter=len.
  - Next cycle: dout = load_data[len-1], dout_valid=1, busy=1.
- SHIFT, each cycle: shift left by one, decrement counter, dout follows the register MSB.
  - The word occupies exactly len consecutive dout_valid cycles.
  - Latency from accept edge to first bit is 1 cycle.
- Last bit (counter==1): done=1 for that cycle.
  - With accept in the same cycle: reload, stay in SHIFT. The next word's first bit follows the previous last bit with no gap; dout_valid never drops.
  - Without accept: return to IDLE. dout_valid=0, dout=0 the following cycle.
- len==1: a single bit. done and dout_valid are asserted together in the same cycle.
- load_valid while load_ready=0: ignored. Data is not captured and no error is flagged; the source must hold it.
- Mid-word reset: aborts immediately (async). No done pulse; the partial word is discarded.
- Bits of load_data above len-1 are don't-care and must not appear on dout.

Optional Feature:
Macro SEQ_PATTERN_GEN_REPEAT_EN.
- Defined:
  - Adds input port repeat (1 bit).
  - When repeat=1 on the last-bit cycle and no new word is accepted, the block reloads the last accepted word and len, and continues gaplessly.
  - done still pulses at the end of each repetition.
  - A new accepted word takes priority over repeat.
  - Clearing repeat lets the current repetition finish, then the block goes to IDLE.
- Not defined: no repeat port; behaviour is exactly as above; the saved-word register is not synthesized.

Test Plan:
1. Reset, then accept load_data=8'h0B, len=4 -> dout 1,0,1,1 on cycles 1-4 after accept; dout_valid high 4 cycles; done on cycle 4; busy low and load_ready=1 on cycle 5; a connected 1011 detector asserts its dout once.
2. Back-to-back: word 0x0B len 4 held valid through completion, then 0x03 len 3 -> stream 1,0,1,1,0,1,1 over 7 unbroken dout_valid cycles; two done pulses (cycles 4 and 7); detector fires twice (overlap).
3. load_len=0 with load_data=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1; len=1 with data=1 -> single bit 1, done and dout_valid in the same cycle.
4. Assert reset_n low during bit 2 of a 4-bit word -> dout/dout_valid/busy go 0 without waiting for a clock edge; no done; load_ready=1 after release; next word sends cleanly.
5. load_valid asserted mid-word (counter>1) with different data -> not captured; the current word completes unchanged; the word is accepted only on the last-bit cycle.
6. (REPEAT_EN) repeat=1, word 0x0B len 4 -> continuous 1011 1011 ...; done every 4 cycles; drop repeat mid-repetition -> that repetition completes, then IDLE.
